// File: rtl/column_frame_buffer_if.sv
// Raycaster handshake: the frame buffer requests a column, the raycaster
// answers with that column's wall span and colour.
interface column_frame_buffer_if;
    logic        col_req;
    logic [9:0]  col_x;
    logic        col_ack;
    logic [8:0]  col_start;
    logic [8:0]  col_end;
    logic [11:0] col_color;

    modport master (output col_req, col_x,
                    input  col_ack, col_start, col_end, col_color);
    modport slave  (input  col_req, col_x,
                    output col_ack, col_start, col_end, col_color);
endinterface

// File: rtl/column_frame_buffer.sv
// Double-buffered per-column wall store. The fill side walks all columns once
// per frame through the raycaster handshake. The scan-out side renders the
// front bank as ceiling/wall/floor bands. Banks swap only at frame_start.
module column_frame_buffer #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter logic [11:0] CEIL_COLOR  = 12'h000,
    parameter logic [11:0] FLOOR_COLOR = 12'h444
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    column_frame_buffer_if.master ray,
    input  logic                 pix_en,
    input  logic [9:0]           pix_x,
    input  logic [8:0]           pix_y,
    output logic [3:0]           red,
    output logic [3:0]           green,
    output logic [3:0]           blue,
    output logic                 fill_busy,
    output logic                 frame_ready,
    output logic                 overrun
);
    localparam logic [9:0] LAST_X = 10'(SCREEN_W - 1);
    localparam logic [9:0] W_X    = 10'(SCREEN_W);
    localparam logic [8:0] H_Y    = 9'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, REQ, DONE} fill_state_t;

    fill_state_t state_q, state_d;
    logic [9:0]  col_x_q, col_x_d;
    logic        front_q, front_d;
    logic        front_valid_q, front_valid_d;
    logic        overrun_q, overrun_d;
    logic        ready_q, ready_d;
    logic        wr_en;
    logic [8:0]  end_w, start_w;
    logic [29:0] wr_data;

    logic [29:0] bank0 [SCREEN_W];
    logic [29:0] bank1 [SCREEN_W];
    logic [29:0] rd0_q, rd1_q, rd_sel;

    logic        s1_en, s1_in, s1_bank;
    logic [8:0]  s1_y;
    logic [11:0] pix_c, rgb_q;

    // Fill state register and swap/status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            col_x_q       <= '0;
            front_q       <= 1'b0;
            front_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_x_q       <= col_x_d;
            front_q       <= front_d;
            front_valid_q <= front_valid_d;
            overrun_q     <= overrun_d;
            ready_q       <= ready_d;
        end
    end

    // Fill next-state: request columns in order, swap on frame_start after DONE
    always_comb begin
        state_d       = state_q;
        col_x_d       = col_x_q;
        front_d       = front_q;
        front_valid_d = front_valid_q;
        overrun_d     = overrun_q;
        ready_d       = 1'b0;
        wr_en         = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = REQ;
                    col_x_d = '0;
                end
            end
            REQ: begin
                // A late frame_start is only flagged; the fill keeps going
                if (frame_start) overrun_d = 1'b1;
                if (ray.col_ack) begin
                    wr_en = 1'b1;
                    if (col_x_q == LAST_X) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                    end else begin
                        col_x_d = col_x_q + 10'd1;
                    end
                end
            end
            DONE: begin
                if (frame_start) begin
                    front_d       = ~front_q;
                    front_valid_d = 1'b1;
                    col_x_d       = '0;
                    state_d       = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clamp the span to the screen; an inverted span collapses to empty
    always_comb begin
        end_w   = (ray.col_end > H_Y) ? H_Y : ray.col_end;
        start_w = (ray.col_start > end_w) ? end_w : ray.col_start;
    end

    assign wr_data     = {start_w, end_w, ray.col_color};
    assign ray.col_req = (state_q == REQ);
    assign ray.col_x   = col_x_q;
    assign fill_busy   = (state_q == REQ);
    assign frame_ready = ready_q;
    assign overrun     = overrun_q;

    // Bank 0: written while it is the back bank, read every cycle
    always_ff @(posedge clk) begin
        if (wr_en && front_q) bank0[col_x_q] <= wr_data;
        rd0_q <= bank0[pix_x];
    end

    // Bank 1: written while it is the back bank, read every cycle
    always_ff @(posedge clk) begin
        if (wr_en && !front_q) bank1[col_x_q] <= wr_data;
        rd1_q <= bank1[pix_x];
    end

    // Stage 1: delay pixel qualifiers alongside the RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_en   <= 1'b0;
            s1_in   <= 1'b0;
            s1_bank <= 1'b0;
            s1_y    <= '0;
        end else begin
            s1_en   <= pix_en;
            s1_in   <= (pix_x < W_X);
            s1_bank <= front_q;
            s1_y    <= pix_y;
        end
    end

    // Stage 2: pick ceiling, wall or floor for the delayed scan position
    always_comb begin
        rd_sel = s1_bank ? rd1_q : rd0_q;
        pix_c  = FLOOR_COLOR;
        if (!s1_en || !s1_in || !front_valid_q) pix_c = '0;
        else if (s1_y < rd_sel[29:21])          pix_c = CEIL_COLOR;
        else if (s1_y < rd_sel[20:12])          pix_c = rd_sel[11:0];
    end

    // Registered pixel output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb_q <= '0;
        else        rgb_q <= pix_c;
    end

    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];
endmodule

// File: tb/tb_column_frame_buffer.sv
// Bench for column_frame_buffer: raycaster model on the fill side, pixel
// scoreboard on the scan-out side.
module tb_column_frame_buffer;
    localparam int SW = 640;
    localparam int SH = 480;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       pix_en = 1'b0;
    logic [9:0] pix_x = '0;
    logic [8:0] pix_y = '0;
    logic [3:0] red, green, blue;
    logic       fill_busy, frame_ready, overrun;

    column_frame_buffer_if rif ();

    column_frame_buffer #(
        .SCREEN_W   (640),
        .SCREEN_H   (480),
        .CEIL_COLOR (12'h000),
        .FLOOR_COLOR(12'h444)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .ray        (rif),
        .pix_en     (pix_en),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .fill_busy  (fill_busy),
        .frame_ready(frame_ready),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Column pattern for the next fill, back-bank model, front-bank model
    int          fs [SW];
    int          fe [SW];
    logic [11:0] fc [SW];
    int          mb_s [SW];
    int          mb_e [SW];
    logic [11:0] mb_c [SW];
    int          mf_s [SW];
    int          mf_e [SW];
    logic [11:0] mf_c [SW];
    bit          m_valid = 1'b0;

    function automatic logic [11:0] exp_pix(input int x, input int y, input bit en);
        if (!en || x >= SW || !m_valid) return 12'h000;
        if (y < mf_s[x]) return 12'h000;
        if (y < mf_e[x]) return mf_c[x];
        return 12'h444;
    endfunction

    // Pixel scoreboard: each entry is due two clocks after it was driven
    typedef struct {
        logic [11:0] exp;
        int unsigned due;
    } pix_t;
    pix_t        pq[$];
    string       tq[$];
    int unsigned cyc = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (pq.size() != 0 && pq[0].due == cyc) begin
            pix_t  p;
            string t;
            p = pq.pop_front();
            t = tq.pop_front();
            check(t, {20'd0, red, green, blue}, {20'd0, p.exp});
        end
    end

    task automatic px(input string tag, input int x, input int y, input bit en, input logic [11:0] exp);
        pix_t p;
        @(negedge clk);
        pix_x  = 10'(x);
        pix_y  = 9'(y);
        pix_en = en;
        p.exp  = exp;
        p.due  = cyc + 2;
        pq.push_back(p);
        tq.push_back(tag);
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        pix_en = 1'b0;
        while (pq.size() != 0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (pq.size() != 0) begin
            check("pix_drain", pq.size(), 0);
            pq.delete();
            tq.delete();
        end
    endtask

    task automatic sweep();
        px("edge_639_0", 639, 0, 1'b1, exp_pix(639, 0, 1'b1));
        px("edge_639_479", 639, 479, 1'b1, exp_pix(639, 479, 1'b1));
        px("edge_640", 640, 200, 1'b1, 12'h000);
        px("edge_en0", 5, 200, 1'b0, 12'h000);
        for (int k = 0; k < 40; k++) begin
            int x, y;
            bit en;
            x  = int'($urandom_range(0, 700));
            y  = int'($urandom_range(0, 511));
            en = ($urandom_range(0, 3) != 0);
            px("sweep", x, y, en, exp_pix(x, y, en));
        end
        drain();
    endtask

    task automatic set_cols(input int s, input int e, input logic [11:0] c);
        for (int i = 0; i < SW; i++) begin
            fs[i] = s;
            fe[i] = e;
            fc[i] = c;
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic do_swap();
        pulse_start();
        for (int i = 0; i < SW; i++) begin
            mf_s[i] = mb_s[i];
            mf_e[i] = mb_e[i];
            mf_c[i] = mb_c[i];
        end
        m_valid = 1'b1;
    endtask

    // Raycaster model: answers each request after 1-2 clocks of latency
    task automatic run_fill(input int ovr_at, input int abort_at);
        for (int i = 0; i < SW; i++) begin
            int t;
            t = 0;
            while (rif.col_req !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) begin
                check("req_wait", 0, 1);
                return;
            end
            check("col_x", rif.col_x, i);
            if (i == 0) check("busy_fill", fill_busy, 1);
            if (i == abort_at) return;
            if (i == ovr_at) begin
                pulse_start();
                check("overrun_set", overrun, 1);
                check("ovr_col_x", rif.col_x, i);
                check("ovr_req", rif.col_req, 1);
            end
            repeat ($urandom_range(1, 2)) @(negedge clk);
            rif.col_start = 9'(fs[i]);
            rif.col_end   = 9'(fe[i]);
            rif.col_color = fc[i];
            rif.col_ack   = 1'b1;
            @(negedge clk);
            rif.col_ack   = 1'b0;
            mb_e[i] = (fe[i] > SH) ? SH : fe[i];
            mb_s[i] = (fs[i] > mb_e[i]) ? mb_e[i] : fs[i];
            mb_c[i] = fc[i];
        end
        check("frame_ready", frame_ready, 1);
        check("req_drop", rif.col_req, 0);
        check("busy_drop", fill_busy, 0);
        @(negedge clk);
        check("frame_ready_pulse", frame_ready, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rif.col_ack   = 1'b0;
        rif.col_start = '0;
        rif.col_end   = '0;
        rif.col_color = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_req", rif.col_req, 0);
        check("rst_col_x", rif.col_x, 0);
        check("rst_busy", fill_busy, 0);
        check("rst_ready", frame_ready, 0);
        check("rst_overrun", overrun, 0);
        px("idle_pix", 5, 200, 1'b1, 12'h000);
        px("idle_pix_oob", 700, 10, 1'b1, 12'h000);
        drain();

        // First fill: red wall, plus a clipped and an inverted span
        set_cols(100, 380, 12'hF00);
        fs[7] = 450; fe[7] = 511; fc[7] = 12'h00F;
        fs[9] = 300; fe[9] = 200; fc[9] = 12'hABC;
        pulse_start();
        run_fill(-1, -1);
        check("overrun_clear", overrun, 0);
        px("pre_swap", 5, 200, 1'b1, 12'h000);
        drain();

        // Swap, then check the red frame while the green fill is pending
        set_cols(100, 380, 12'h0F0);
        do_swap();
        px("ceil_5_50", 5, 50, 1'b1, 12'h000);
        px("wall_5_200", 5, 200, 1'b1, 12'hF00);
        px("floor_5_400", 5, 400, 1'b1, 12'h444);
        px("c7_449", 7, 449, 1'b1, 12'h000);
        px("c7_450", 7, 450, 1'b1, 12'h00F);
        px("c7_479", 7, 479, 1'b1, 12'h00F);
        px("c7_480", 7, 480, 1'b1, 12'h444);
        px("c9_199", 9, 199, 1'b1, 12'h000);
        px("c9_200", 9, 200, 1'b1, 12'h444);
        px("c9_350", 9, 350, 1'b1, 12'h444);
        drain();
        sweep();
        run_fill(-1, -1);
        px("still_red", 5, 200, 1'b1, 12'hF00);
        drain();

        // Third frame_start shows green; next fill is overrun mid-way
        set_cols(50, 430, 12'h0FF);
        do_swap();
        px("green", 5, 200, 1'b1, 12'h0F0);
        px("green_639", 639, 379, 1'b1, 12'h0F0);
        drain();
        run_fill(300, -1);
        check("overrun_sticky", overrun, 1);
        px("no_swap", 5, 200, 1'b1, 12'h0F0);
        drain();
        set_cols(100, 380, 12'h123);
        do_swap();
        px("cyan_ceil", 5, 40, 1'b1, 12'h000);
        px("cyan_wall", 5, 200, 1'b1, 12'h0FF);
        px("cyan_floor", 5, 440, 1'b1, 12'h444);
        drain();
        sweep();
        check("overrun_sticky2", overrun, 1);

        // Reset in the middle of a fill
        run_fill(-1, 123);
        rst_n = 1'b0;
        #1;
        check("mrst_req", rif.col_req, 0);
        check("mrst_col_x", rif.col_x, 0);
        check("mrst_busy", fill_busy, 0);
        check("mrst_ready", frame_ready, 0);
        check("mrst_overrun", overrun, 0);
        check("mrst_rgb", {red, green, blue}, 0);
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        px("post_rst_pix", 5, 200, 1'b1, 12'h000);
        drain();
        rif.col_ack = 1'b1;
        @(negedge clk);
        rif.col_ack = 1'b0;
        check("idle_ack_req", rif.col_req, 0);
        check("idle_ack_x", rif.col_x, 0);
        pulse_start();
        check("restart_req", rif.col_req, 1);
        check("restart_x", rif.col_x, 0);
        check("restart_busy", fill_busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/column_frame_buffer.md
# column_frame_buffer

Downstream stage of the raycaster. Once per frame it walks every screen column, hands each column index to the raycaster, and captures the per-column wall span and colour into a double-buffered column store. The scan-out side reads the front bank at the VGA pixel rate and produces 4-bit RGB with ceiling, wall and floor bands. Banks swap only at frame boundaries, so the display never tears.

## Interface
- SCREEN_W, 640, columns per frame.
- SCREEN_H, 480, lines per frame.
- CEIL_COLOR, 12'h000, RGB444 above the wall span.
- FLOOR_COLOR, 12'h444, RGB444 below the wall span.

Ports:
- clk  in  1  pixel-domain clock; all logic runs on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse at the start of vertical blanking.
- col_req  out  1  request to the raycaster; held high until acknowledged.
- col_x  out  10  column being requested; stable while col_req is high.
- col_ack  in  1  single-cycle pulse; raycaster result for col_x is valid.
- col_start  in  9  first wall line (inclusive).
- col_end  in  9  last wall line (exclusive).
- col_color  in  12  RGB444 wall colour, side shading already applied.
- pix_en  in  1  active-video qualifier.
- pix_x  in  10  scan column.
- pix_y  in  9  scan line.
- red, green, blue  out  4 each  registered pixel colour.
- fill_busy  out  1  high while a fill is in progress.
- frame_ready  out  1  one-cycle pulse when the back bank is complete.
- overrun  out  1  sticky; frame_start arrived while a fill was still running.

## Operation
- Storage: two banks, each SCREEN_W entries of {start[8:0], end[8:0], color[11:0]} (30 bits). Each bank is synchronous-read block RAM.
- Register `front` selects the displayed bank. The fill side always writes `!front`. Flag `front_valid` is cleared by reset.

Fill state machine (IDLE, REQ, DONE):
- IDLE -> REQ on frame_start: col_x=0, col_req=1, fill_busy=1.
- REQ -> REQ when col_ack arrives and col_x < SCREEN_W-1:
  - The entry is written to the back bank at col_x.
  - On the next cycle col_x increments and col_req stays high.
- REQ -> DONE when col_ack arrives and col_x == SCREEN_W-1:
  - col_req=0, fill_busy=0, frame_ready pulses.
- DONE on frame_start, all in the same cycle:
  - `front` toggles and front_valid is set.
  - The next fill starts (col_x=0, col_req=1), i.e. the state goes to REQ.
- frame_start while in REQ:
  - overrun is set.
  - No swap and no restart; the current fill continues.
  - The swap waits for the next frame_start after DONE.
- col_ack is ignored outside REQ.

Write sanitising:
- end_w = min(col_end, SCREEN_H).
- start_w = min(col_start, end_w), so start > end stores an empty span.

Scan-out pipeline:
- Stage 1: RAM read of front[pix_x]. pix_y, pix_en and (pix_x < SCREEN_W) are delayed alongside.
- Stage 2 colour selection, then register:
  - Output 0 if the delayed pix_en is 0, the column is out of range, or front_valid is 0.
  - Otherwise CEIL_COLOR if y < start.
  - Otherwise the stored color if y < end.
  - Otherwise FLOOR_COLOR.
- red=c[11:8], green=c[7:4], blue=c[3:0].
- A swap takes effect for reads issued on the cycle after the toggle. A swap only happens at frame_start, which is in blanking, so no visible pixel changes bank mid-line.

## Timing
- Reset values:
  - Outputs: col_req=0, col_x=0, fill_busy=0, frame_ready=0, overrun=0, red/green/blue=0.
  - Internal: state=IDLE, front=0, front_valid=0.
- RAM contents are not reset; front_valid masks them.
- Scan-out latency is 2 clocks, from pix_x/pix_y/pix_en to RGB, fully pipelined at 1 pixel/clock.
- Fill throughput is 1 column per (raycaster latency + 1) clocks minimum.
  - col_ack may come on the cycle immediately after col_req rises.
  - Minimum fill time is 2*SCREEN_W clocks.
- The write lands in the cycle of col_ack; the next request's col_x is visible one clock later.
- A reset during a fill aborts it. The old back-bank data is discarded because front_valid=0.
- Bank indices wrap nowhere: col_x never exceeds SCREEN_W-1.

## Test plan
- Reset and idle: release rst_n and drive pix_en=1 with any x/y -> RGB=0, col_req=0, overrun=0.
- Single fill and swap:
  - Stimulus: frame_start; ack every column with start=100, end=380, color=12'hF00; then a second frame_start.
  - Required: frame_ready pulses after col 639.
  - Required after the swap: (x=5,y=50) -> 0/0/0; (5,200) -> F/0/0; (5,400) -> 4/4/4, each 2 clocks after the input.
- Double buffering:
  - Stimulus: during the second fill, write color 12'h0F0 for all columns.
  - Required: display stays red until the third frame_start, then reads green.
- Overrun:
  - Stimulus: frame_start mid-fill (col_x=300).
  - Required: overrun=1 and sticky; no swap; the fill finishes at 639; the next frame_start swaps.
- Sanitising:
  - Stimulus: col_start=450, col_end=511 at col 7.
  - Required: the stored span is 450..480; y=479 gives wall colour.
  - Stimulus: col_start=300, col_end=200.
  - Required: no wall pixels; ceiling for y<200, floor for y>=200.
- Mid-fill reset:
  - Stimulus: assert rst_n low at col_x=123.
  - Required: all outputs return to reset values immediately; after release, the first frame_start restarts at col_x=0.
